mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 32-bit memory port (cache side) between NUM_REQ requesters:
//  packet_loader, memory_accessor and any later master. Round-robin grant, one
//  outstanding transaction, read response routed back to the owner.
//  Sits between the requesters' MEM_SEND/MEM_RECEIVE channels and the cache.
// PARAMETERS
//  NUM_REQ     2   number of requesters (2..8); index 0 = packet_loader
//  ADDR_WIDTH  32  address width
//  DATA_WIDTH  32  data width
// PORTS
//  CLK                  in   1              clock, all logic on posedge
//  RST_N                in   1              asynchronous, active-low reset
//  REQ_SEND_ADDR_VALID  in   NUM_REQ        per-requester address valid
//  REQ_SEND_ADDR        in   NUM_REQ*32     flattened addresses, req i at [i*32+:32]
//  REQ_SEND_DATA_VALID  in   NUM_REQ        1 = write (data with address), 0 = read
//  REQ_SEND_DATA        in   NUM_REQ*32     flattened write data
//  REQ_SEND_READY       out  NUM_REQ        send handshake back to requester
//  REQ_LOCK             in   NUM_REQ        keep grant after current transaction
//  REQ_RECEIVE_VALID    out  NUM_REQ        read response valid, one-hot to owner
//  REQ_RECEIVE_DATA     out  32             read data (shared, qualify with valid)
//  REQ_RECEIVE_READY    in   NUM_REQ        requester accepts response
//  MEM_SEND_ADDR_VALID  out  1              to cache
//  MEM_SEND_ADDR        out  32
//  MEM_SEND_DATA_VALID  out  1
//  MEM_SEND_DATA        out  32
//  MEM_SEND_READY       in   1
//  MEM_RECEIVE_VALID    in   1              from cache
//  MEM_RECEIVE_DATA     in   32
//  MEM_RECEIVE_READY    out  1
// BEHAVIOUR
//  - Requester request = REQ_SEND_ADDR_VALID[i]; requester holds valid/addr/data
//    stable until REQ_SEND_READY[i] handshake (valid/ready, transfer on both high).
//  - State reg, 2 bits: S_IDLE, S_SEND, S_RECEIVE. Regs: STATE, grant (3b), rr_ptr (3b).
//  - Reset (RST_N low, async): STATE=S_IDLE, grant=0, rr_ptr=0. All outputs are
//    state-gated, so all valid/ready outputs read 0 during and after reset.
//  - S_IDLE: pick first i with ADDR_VALID[i] scanning rr_ptr, rr_ptr+1, .. mod NUM_REQ;
//    if any: grant<=i, STATE<=S_SEND. None: stay. Request at cycle t -> MEM_SEND at t+1.
//  - S_SEND: combinational pass-through of requester grant: MEM_SEND_* = REQ_SEND_*[grant],
//    REQ_SEND_READY[grant]=MEM_SEND_READY, all other READY bits 0.
//    On MEM handshake: write (DATA_VALID[grant]=1) -> transaction done; read -> S_RECEIVE.
//  - S_RECEIVE: MEM_RECEIVE_READY = REQ_RECEIVE_READY[grant]; REQ_RECEIVE_VALID[grant] =
//    MEM_RECEIVE_VALID, others 0; data passed through. Handshake -> transaction done.
//  - Outside S_SEND: MEM_SEND_*_VALID=0, REQ_SEND_READY=0. Outside S_RECEIVE:
//    MEM_RECEIVE_READY=0, REQ_RECEIVE_VALID=0 (stray cache responses are not consumed).
//  - Transaction done: rr_ptr<=(grant+1) mod NUM_REQ. If REQ_LOCK[grant]=1 in that cycle
//    and ADDR_VALID[grant]=1: STATE<=S_SEND, grant kept (burst, no idle bubble);
//    if LOCK=1 but no valid: STATE<=S_IDLE. Otherwise STATE<=S_IDLE.
//  - Wrap: rr_ptr mod NUM_REQ, never holds value >= NUM_REQ.
//  - Requester dropping ADDR_VALID in S_SEND before handshake: protocol violation,
//    arbiter keeps waiting (no timeout). Reset mid-transaction abandons it; cache and
//    requesters share RST_N.
//  - Fairness: with all requesters continuously requesting and no LOCK, grants rotate
//    0,1,..,NUM_REQ-1,0; max wait = NUM_REQ-1 transactions.
// STRUCTURE
//  - include/param.vh: MEM_ADDR_WIDTH, MEM_DATA_WIDTH, NUM_MEM_REQ; state localparams
//    MA_S_IDLE/MA_S_SEND/MA_S_RECEIVE local to this file.
//  - One sub-module: rr_picker (in: req vector, ptr; out: found, index), combinational.
//  - Top: state/grant/rr_ptr regs plus output muxes.
// TESTING
//  1 Single read: req0 addr 0x100 at t, cache READY=1 -> MEM_SEND_ADDR=0x100 valid at t+1;
//    response 0xDEADBEEF -> REQ_RECEIVE_VALID=2'b01, data 0xDEADBEEF, then S_IDLE.
//  2 Contention: req0 and req1 valid continuously, 4 reads each -> grant order 0,1,0,1,..
//  3 Write: req1 DATA_VALID=1 addr 0x40 data 0x5 -> MEM_SEND_DATA_VALID=1, no S_RECEIVE,
//    next grant req0 if pending.
//  4 Lock burst: req0 LOCK=1 for 6 reads (packet_loader pattern), req1 waiting ->
//    six consecutive req0 grants, no S_IDLE cycle between; req1 granted 7th.
//  5 Backpressure: MEM_SEND_READY low 3 cycles, REQ_RECEIVE_READY low 2 cycles ->
//    outputs held stable, no other requester's READY/VALID asserted.
//  6 Async reset asserted mid-S_RECEIVE -> all valid/ready outputs 0 immediately, rr_ptr=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM states and the
// round-robin wrap helper used by the arbiter and its picker.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_DATA_WIDTH = 32;
   localparam int NUM_MEM_REQ    = 2;

   typedef enum logic [1:0] {
      MA_S_IDLE    = 2'd0,
      MA_S_SEND    = 2'd1,
      MA_S_RECEIVE = 2'd2
   } ma_state_t;

   // (v + 1) mod n for a 3-bit requester index
   function automatic logic [2:0] ma_wrap_inc(
      input logic [2:0] v,
      input int         n
   );
      if (int'(v) >= n - 1) return 3'd0;
      return v + 3'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker: first set bit of req scanning ptr, ptr+1, ..
// mod NUM_REQ. In: req, ptr. Out: found, index. Purely combinational.
module mem_arbiter_rr_picker
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic               found,
   output logic [2:0]         index
);

   logic [7:0] req_x;
   logic [2:0] cand;

   always_comb begin
      req_x                = '0;
      req_x[NUM_REQ-1:0]   = req;
      found                = 1'b0;
      index                = 3'd0;
      cand                 = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_x[cand]) begin
            found = 1'b1;
            index = cand;
         end
         cand = ma_wrap_inc(cand, NUM_REQ);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one cache port by NUM_REQ masters.
// Ports: CLK, RST_N; REQ_SEND_* / REQ_LOCK / REQ_RECEIVE_* per requester
// (flattened, req i at [i*W+:W]); MEM_SEND_* / MEM_RECEIVE_* to the cache.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = NUM_MEM_REQ,
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [NUM_REQ-1:0]            REQ_SEND_ADDR_VALID,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_SEND_ADDR,
   input  logic [NUM_REQ-1:0]            REQ_SEND_DATA_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_SEND_DATA,
   output logic [NUM_REQ-1:0]            REQ_SEND_READY,
   input  logic [NUM_REQ-1:0]            REQ_LOCK,
   output logic [NUM_REQ-1:0]            REQ_RECEIVE_VALID,
   output logic [DATA_WIDTH-1:0]         REQ_RECEIVE_DATA,
   input  logic [NUM_REQ-1:0]            REQ_RECEIVE_READY,
   output logic                          MEM_SEND_ADDR_VALID,
   output logic [ADDR_WIDTH-1:0]         MEM_SEND_ADDR,
   output logic                          MEM_SEND_DATA_VALID,
   output logic [DATA_WIDTH-1:0]         MEM_SEND_DATA,
   input  logic                          MEM_SEND_READY,
   input  logic                          MEM_RECEIVE_VALID,
   input  logic [DATA_WIDTH-1:0]         MEM_RECEIVE_DATA,
   output logic                          MEM_RECEIVE_READY
);

   ma_state_t  state;
   logic [2:0] grant;
   logic [2:0] rr_ptr;

   logic       pick_found;
   logic [2:0] pick_idx;

   // per-requester inputs widened to 8 so a 3-bit grant indexes exactly
   logic [7:0] av_x;
   logic [7:0] dv_x;
   logic [7:0] lk_x;
   logic [7:0] rxr_x;

   logic [ADDR_WIDTH-1:0] addr_a [8];
   logic [DATA_WIDTH-1:0] data_a [8];

   logic in_send;
   logic in_recv;
   logic g_av;
   logic g_dv;
   logic send_hs;
   logic recv_hs;
   logic done;
   logic burst;

   always_comb begin
      av_x                = '0;
      dv_x                = '0;
      lk_x                = '0;
      rxr_x               = '0;
      av_x[NUM_REQ-1:0]   = REQ_SEND_ADDR_VALID;
      dv_x[NUM_REQ-1:0]   = REQ_SEND_DATA_VALID;
      lk_x[NUM_REQ-1:0]   = REQ_LOCK;
      rxr_x[NUM_REQ-1:0]  = REQ_RECEIVE_READY;
   end

   for (genvar g = 0; g < 8; g++) begin : g_unpack
      if (g < NUM_REQ) begin : g_on
         assign addr_a[g] = REQ_SEND_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
         assign data_a[g] = REQ_SEND_DATA[g*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_off
         assign addr_a[g] = '0;
         assign data_a[g] = '0;
      end
   end

   mem_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (REQ_SEND_ADDR_VALID),
      .ptr   (rr_ptr),
      .found (pick_found),
      .index (pick_idx)
   );

   assign in_send = (state == MA_S_SEND);
   assign in_recv = (state == MA_S_RECEIVE);
   assign g_av    = av_x[grant];
   assign g_dv    = dv_x[grant];

   assign MEM_SEND_ADDR_VALID = in_send & g_av;
   assign MEM_SEND_ADDR       = addr_a[grant];
   assign MEM_SEND_DATA_VALID = in_send & g_dv;
   assign MEM_SEND_DATA       = data_a[grant];
   assign MEM_RECEIVE_READY   = in_recv & rxr_x[grant];
   assign REQ_RECEIVE_DATA    = MEM_RECEIVE_DATA;

   always_comb begin
      REQ_SEND_READY    = '0;
      REQ_RECEIVE_VALID = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         REQ_SEND_READY[i] =
            in_send & MEM_SEND_READY & (grant == 3'(i));
         REQ_RECEIVE_VALID[i] =
            in_recv & MEM_RECEIVE_VALID & (grant == 3'(i));
      end
   end

   assign send_hs = MEM_SEND_ADDR_VALID & MEM_SEND_READY;
   assign recv_hs = MEM_RECEIVE_VALID & MEM_RECEIVE_READY;
   assign done    = (send_hs & g_dv) | recv_hs;
   // owner already presents its next request while locked: no idle bubble
   assign burst   = lk_x[grant] & g_av;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= MA_S_IDLE;
         grant  <= 3'd0;
         rr_ptr <= 3'd0;
      end else begin
         unique case (state)
            MA_S_IDLE: begin
               if (pick_found) begin
                  grant <= pick_idx;
                  state <= MA_S_SEND;
               end
            end
            MA_S_SEND: begin
               if (send_hs) begin
                  if (!g_dv)      state <= MA_S_RECEIVE;
                  else if (burst) state <= MA_S_SEND;
                  else            state <= MA_S_IDLE;
               end
            end
            MA_S_RECEIVE: begin
               if (recv_hs) begin
                  state <= burst ? MA_S_SEND : MA_S_IDLE;
               end
            end
            default: state <= MA_S_IDLE;
         endcase
         if (done) rr_ptr <= ma_wrap_inc(grant, NUM_REQ);
      end
   end

endmodule
